// File: rtl/prog_updown_counter.sv
// Programmable up/down timer/counter with a prescaler, wrap/saturate/one-shot terminal
// behaviour, a registered terminal-count pulse and a sticky overflow flag.
module prog_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               en,
  input  logic               up_downN,
  input  logic               load,
  input  logic [WIDTH-1:0]   initialCount,
  input  logic [WIDTH-1:0]   maxCount,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               clrFlags,
  output logic [WIDTH-1:0]   currentCount,
  output logic               tc,
  output logic               overflow,
  output logic               running
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic               tc_reg, tc_next;
  logic               ovf_reg, ovf_next;
  logic               tick;
  logic               terminal;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= RUN;
      count_reg <= '0;
      presc_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      presc_reg <= presc_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    presc_next = presc_reg;
    tick       = 1'b0;
    terminal   = 1'b0;

    if (en) begin
      if (load) begin
        count_next = (initialCount > maxCount) ? maxCount : initialCount;
        presc_next = '0;
        state_next = RUN;
      end else if (state_reg == RUN) begin
        // >= rather than == so lowering prescale mid-count cannot strand the prescaler
        if (presc_reg >= prescale) begin
          tick       = 1'b1;
          presc_next = '0;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
    end

    if (tick) begin
      if (up_downN) begin
        if (count_reg >= maxCount) begin
          terminal = 1'b1;
          case (mode)
            MODE_SAT:     count_next = maxCount;
            MODE_ONESHOT: state_next = HALT;
            default:      count_next = '0;
          endcase
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
          terminal = 1'b1;
          case (mode)
            MODE_SAT:     count_next = '0;
            MODE_ONESHOT: state_next = HALT;
            default:      count_next = maxCount;
          endcase
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end

    tc_next = terminal;

    // a terminal event beats a simultaneous clear; clear works even while disabled
    if (terminal) begin
      ovf_next = 1'b1;
    end else if (clrFlags) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_reg;
    end
  end

  assign currentCount = count_reg;
  assign tc           = tc_reg;
  assign overflow     = ovf_reg;
  assign running      = (state_reg == RUN);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter: each driven cycle pushes its expected
// outputs, which are popped and compared one time unit after the clock edge.
module tb_prog_updown_counter;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       en = 1'b0;
  logic       up_downN = 1'b1;
  logic       load = 1'b0;
  logic [7:0] initialCount = '0;
  logic [7:0] maxCount = 8'd9;
  logic [1:0] mode = 2'b00;
  logic [7:0] prescale = '0;
  logic       clrFlags = 1'b0;
  logic [7:0] currentCount;
  logic       tc;
  logic       overflow;
  logic       running;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       ovf;
    logic       run;
  } exp_t;

  exp_t sb_q[$];

  prog_updown_counter #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .en           (en),
    .up_downN     (up_downN),
    .load         (load),
    .initialCount (initialCount),
    .maxCount     (maxCount),
    .mode         (mode),
    .prescale     (prescale),
    .clrFlags     (clrFlags),
    .currentCount (currentCount),
    .tc           (tc),
    .overflow     (overflow),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".count"},    32'(currentCount), 32'(e.count));
    check({tag, ".tc"},       32'(tc),           32'(e.tc));
    check({tag, ".overflow"}, 32'(overflow),     32'(e.ovf));
    check({tag, ".running"},  32'(running),      32'(e.run));
  endtask

  // Drive one clock cycle of stimulus, queue its expected result, compare after the edge.
  task automatic cyc(input logic en_v, input logic ld, input logic [7:0] init_v, input logic clr,
                     input logic [7:0] ec, input logic et, input logic eo, input logic er,
                     input string tag);
    exp_t e;
    en = en_v;
    load = ld;
    initialCount = init_v;
    clrFlags = clr;
    sb_q.push_back('{count: ec, tc: et, ovf: eo, run: er});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("[TB] %s: count=%0d tc=%0b ovf=%0b run=%0b (exp %0d %0b %0b %0b)",
             tag, currentCount, tc, overflow, running, e.count, e.tc, e.ovf, e.run);
    check_outputs(tag, e);
  endtask

  task automatic step(input logic [7:0] ec, input logic et, input logic eo, input logic er,
                      input string tag);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, ec, et, eo, er, tag);
  endtask

  initial begin
    exp_t r;
    #12;
    r = '{count: 8'd0, tc: 1'b0, ovf: 1'b0, run: 1'b1};
    check_outputs("reset", r);
    resetN = 1'b1;

    // 1: wrap up, max 9, prescale 0
    mode = 2'b00; up_downN = 1'b1; maxCount = 8'd9; prescale = 8'd0;
    cyc(1, 1, 8'd7, 0, 8'd7, 0, 0, 1, "t1.load7");
    step(8'd8, 0, 0, 1, "t1.s8");
    step(8'd9, 0, 0, 1, "t1.s9");
    step(8'd0, 1, 1, 1, "t1.wrap0");
    step(8'd1, 0, 1, 1, "t1.s1");
    cyc(0, 0, 8'd0, 1, 8'd1, 0, 0, 1, "t1.clr");

    // 2: wrap down, max 9; oversize load clamps
    up_downN = 1'b0;
    cyc(1, 1, 8'd1, 0, 8'd1, 0, 0, 1, "t2.load1");
    step(8'd0, 0, 0, 1, "t2.s0");
    step(8'd9, 1, 1, 1, "t2.wrap9");
    step(8'd8, 0, 1, 1, "t2.s8");
    cyc(1, 1, 8'd12, 0, 8'd9, 0, 1, 1, "t2.load12");
    cyc(0, 0, 8'd0, 1, 8'd9, 0, 0, 1, "t2.clr");

    // 3: saturate up, max 255
    mode = 2'b01; up_downN = 1'b1; maxCount = 8'd255;
    cyc(1, 1, 8'd254, 0, 8'd254, 0, 0, 1, "t3.load254");
    step(8'd255, 0, 0, 1, "t3.s255");
    for (int i = 0; i < 3; i++) step(8'd255, 1, 1, 1, $sformatf("t3.sat%0d", i));
    cyc(0, 0, 8'd0, 1, 8'd255, 0, 0, 1, "t3.clr");

    // 4: one-shot down, prescale 2
    mode = 2'b10; up_downN = 1'b0; maxCount = 8'd9; prescale = 8'd2;
    cyc(1, 1, 8'd3, 0, 8'd3, 0, 0, 1, "t4.load3");
    for (int v = 3; v >= 1; v--) begin
      step(8'(v), 0, 0, 1, $sformatf("t4.p1_%0d", v));
      step(8'(v), 0, 0, 1, $sformatf("t4.p2_%0d", v));
      step(8'(v - 1), 0, 0, 1, $sformatf("t4.tick_%0d", v - 1));
    end
    step(8'd0, 0, 0, 1, "t4.p1_0");
    step(8'd0, 0, 0, 1, "t4.p2_0");
    step(8'd0, 1, 1, 0, "t4.halt");
    for (int i = 0; i < 3; i++) step(8'd0, 0, 1, 0, $sformatf("t4.held%0d", i));
    cyc(1, 1, 8'd5, 0, 8'd5, 0, 1, 1, "t4.reload5");
    step(8'd5, 0, 1, 1, "t4.r_p1");
    step(8'd5, 0, 1, 1, "t4.r_p2");
    step(8'd4, 0, 1, 1, "t4.r_tick4");

    // 5: simultaneous events and freeze
    mode = 2'b00; up_downN = 1'b1; prescale = 8'd0;
    cyc(1, 0, 8'd0, 1, 8'd5, 0, 0, 1, "t5.step_clr");
    cyc(1, 1, 8'd2, 0, 8'd2, 0, 0, 1, "t5.load_over_tick");
    cyc(1, 1, 8'd9, 0, 8'd9, 0, 0, 1, "t5.load9");
    cyc(1, 0, 8'd0, 1, 8'd0, 1, 1, 1, "t5.term_vs_clr");
    cyc(0, 0, 8'd0, 0, 8'd0, 0, 1, 1, "t5.en0_tcdrop");
    prescale = 8'd2;
    step(8'd0, 0, 1, 1, "t5.p1");
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'd0, 0, 8'd0, 0, 1, 1, $sformatf("t5.frozen%0d", i));
    step(8'd0, 0, 1, 1, "t5.p2");
    step(8'd1, 0, 1, 1, "t5.tick1");

    // 6: asynchronous reset mid-count
    prescale = 8'd0; maxCount = 8'd255;
    cyc(1, 1, 8'h5A, 0, 8'h5A, 0, 1, 1, "t6.load5A");
    en = 1'b0;
    #3;
    resetN = 1'b0;
    #1;
    r = '{count: 8'd0, tc: 1'b0, ovf: 1'b0, run: 1'b1};
    $display("[TB] t6.async: count=%0d tc=%0b ovf=%0b run=%0b", currentCount, tc, overflow, running);
    check_outputs("t6.async", r);
    #2;
    resetN = 1'b1;
    step(8'd1, 0, 0, 1, "t6.resume");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
